// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and defaults for the RAM access controller.
// State encoding plus the RAM / MAR / MDR width defaults.
package mem_access_ctrl_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// One-at-a-time load/store controller in front of a sync RAM.
// Ports: clock/clear, req_* in, resp_* out, ram_* to/from RAM.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_write,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  localparam logic [1:0] LAT_M1 = 2'(READ_LATENCY - 1);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;
  logic [1:0]        cnt_q;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      cnt_q      <= 2'd0;
      resp_rdata <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wr_q    <= req_write;
      end
      if (state == ISSUE && !wr_q) begin
        cnt_q <= LAT_M1;
      end else if (state == WAIT && cnt_q != 2'd0) begin
        cnt_q <= cnt_q - 2'd1;
      end
      if (state == WAIT && cnt_q == 2'd0) begin
        resp_rdata <= ram_data_out;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_write = 1'b0;
    ram_read   = 1'b0;
    ram_write  = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = ISSUE;
      end
      ISSUE: begin
        ram_write = wr_q;
        ram_read  = !wr_q;
        state_nx  = wr_q ? DONE : WAIT;
      end
      WAIT: begin
        if (cnt_q == 2'd0) state_nx = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_write = wr_q;
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Held from the latches so the RAM sees a stable address in WAIT.
  assign ram_address = addr_q;
  assign ram_data_in = wdata_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Request/response controller sitting directly upstream of the 512x32 synchronous RAM.
- Accepts one load or store at a time from the CPU datapath (MAR/MDR side) over a valid/ready handshake.
- Drives the RAM Read/Write/address/DataIn pins and captures RAM DataOut after the RAM's registered read latency.
- Returns read data to the datapath over a valid/ready response handshake.

Parameters:
- ADDR_W, 9, RAM word-address width (512 words).
- DATA_W, 32, data word width.
- READ_LATENCY, 1, clock edges from the edge that samples ram_read to valid ram_data_out; legal range 1..4.

Ports:
- clock  in  1  system clock, all state updates on the rising edge.
- clear  in  1  asynchronous, active-low reset.
- req_valid  in  1  datapath presents a request.
- req_ready  out  1  controller accepts a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- resp_valid  out  1  access complete; resp_rdata valid for loads.
- resp_ready  in  1  datapath consumes the response.
- resp_write  out  1  echo of the completed request type.
- resp_rdata  out  DATA_W  last captured load data.
- ram_read  out  1  to RAM Read.
- ram_write  out  1  to RAM Write.
- ram_address  out  ADDR_W  to RAM address.
- ram_data_in  out  DATA_W  to RAM DataIn.
- ram_data_out  in  DATA_W  from RAM DataOut.

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE.
- Reset (clear=0, asynchronous): state=IDLE; latched addr, wdata, write flag, resp_rdata and wait counter all cleared to 0.
  - Consequences: req_ready=1, resp_valid=0, ram_read=0, ram_write=0, ram_address=0, ram_data_in=0, resp_write=0.
- IDLE:
  - req_ready=1.
  - On req_valid: latch req_addr, req_wdata and req_write; go to ISSUE.
- ISSUE (exactly one cycle):
  - ram_address and ram_data_in driven from the latches.
  - ram_write = write flag; ram_read = not write flag. Never both high.
  - Store: go to DONE.
  - Load: load the wait counter with READ_LATENCY-1 and go to WAIT.
- WAIT:
  - ram_read=0, ram_write=0; ram_address stays held.
  - Counter = 0: capture ram_data_out into resp_rdata and go to DONE. Otherwise decrement.
- DONE:
  - resp_valid=1, resp_write = latched write flag, req_ready=0.
  - On resp_ready: go to IDLE.
  - Holds indefinitely without resp_ready; resp_valid stays asserted and resp_rdata stays stable.
- Timing, with the request accepted at edge 0:
  - Store: ram_write high in cycle 1; resp_valid in cycle 2.
  - Load, READ_LATENCY=1: ram_read high in cycle 1, capture at the end of cycle 2, resp_valid in cycle 3.
  - General load: resp_valid READ_LATENCY+2 cycles after acceptance.
- resp_rdata changes only on a load capture; stores leave it unchanged.
- ram_read and ram_write are decoded combinationally from the state register and latches, so async reset deasserts them immediately.
- Reset mid-ISSUE: the RAM write may or may not complete, depending on whether clear releases before the edge; no response is produced.
- Reset in WAIT or DONE: the response is dropped.
- Back-to-back requests: a new request is accepted only in IDLE. With resp_ready tied high, the minimum store rate is one per 3 cycles.
- Store followed by a load of the same address returns the new data; the RAM write completes at the ISSUE edge.
- Address wrap: none; all 2^ADDR_W addresses are legal.
- req_* inputs are ignored outside IDLE.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3), plus ADDR_W/DATA_W defaults shared with the RAM and MAR/MDR.
- No sub-module required. The wait counter is a 2-bit down-counter inline.
- The top-level wrapper instantiates mem_access_ctrl next to the RAM.

Test Plan:
- Reset: hold clear=0 with req_valid=1 -> req_ready=1, resp_valid=0, ram_read=ram_write=0. No state change until clear=1.
- Store then load: store addr 9'h05 data 32'hDEADBEEF -> ram_write=1 with ram_address=5 in cycle 1, resp_valid in cycle 2. Then load addr 5 -> resp_rdata=32'hDEADBEEF, resp_valid 3 cycles after acceptance.
- Backpressure: hold resp_ready=0 for 10 cycles after a load of addr 9'h1FF preloaded with 32'h12345678 -> resp_valid stays 1, resp_rdata stays stable, req_ready stays 0. A req_valid presented meanwhile is not accepted.
- Latency parameter: READ_LATENCY=3, load addr 9'h0A -> capture exactly 3 edges after the ram_read edge; resp_valid 5 cycles after acceptance.
- Reset mid-WAIT: pulse clear low during WAIT -> resp_valid never asserts, state returns to IDLE, resp_rdata=0. A subsequent load of addr 0 completes normally.
- Mutual exclusion: random 1000-request mix -> ram_read and ram_write never high together; every accepted request yields exactly one resp_valid handshake.
